// File: rtl/avl_st_pkg.sv
// Shared Avalon-ST arbiter types and helpers.
// Holds the arbiter FSM state encoding and a width helper used for parameter defaults.
package avl_st_pkg;

    typedef enum logic {ARB_IDLE_S, ARB_PASS_S} arb_state_t;

    // Width helper that never returns zero, for fields like empty on narrow buses.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Searches upward from last+1 (mod N) and reports the first requesting index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int unsigned pos;

    // Scan from farthest to nearest so the closest requester after 'last' wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        pos     = 0;
        for (int i = N; i >= 1; i--) begin
            pos = (32'(last) + 32'(i)) % 32'(N);
            if (req[pos[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ast_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one Avalon-ST datapath among N_PORTS sources.
// Grants are held sop..eop; stray non-sop beats from non-granted ports are drained and counted.
module ast_pkt_arbiter
    import avl_st_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int DATA_W     = 64,
    parameter int EMPTY_W    = clog2_min1(DATA_W / 8),
    parameter int CHANNEL_W  = 10,
    parameter int DROP_CNT_W = 16,
    localparam int GNT_W     = $clog2(N_PORTS)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_PORTS-1:0][DATA_W-1:0]     ast_data_i,
    input  logic [N_PORTS-1:0]                 ast_startofpacket_i,
    input  logic [N_PORTS-1:0]                 ast_endofpacket_i,
    input  logic [N_PORTS-1:0]                 ast_valid_i,
    input  logic [N_PORTS-1:0][EMPTY_W-1:0]    ast_empty_i,
    input  logic [N_PORTS-1:0][CHANNEL_W-1:0]  ast_channel_i,
    output logic [N_PORTS-1:0]                 ast_ready_o,
    output logic [DATA_W-1:0]                  ast_data_o,
    output logic                               ast_startofpacket_o,
    output logic                               ast_endofpacket_o,
    output logic                               ast_valid_o,
    output logic [EMPTY_W-1:0]                 ast_empty_o,
    output logic [CHANNEL_W-1:0]               ast_channel_o,
    input  logic                               ast_ready_i,
    output logic [GNT_W-1:0]                   grant_o,
    output logic                               busy_o,
    output logic [DROP_CNT_W-1:0]              drop_cnt_o
);

    // Handshake: a beat moves on any interface exactly when valid and ready are both
    // high at a rising edge; valid never depends on ready, ready may depend on valid.

    arb_state_t            state_q, state_d;
    logic [GNT_W-1:0]      grant_q, grant_d;
    logic [GNT_W-1:0]      last_q, last_d;
    logic [DROP_CNT_W-1:0] drop_q;
    logic [DROP_CNT_W:0]   drop_sum;
    logic [N_PORTS-1:0]    req;
    logic [N_PORTS-1:0]    drain;
    logic [GNT_W-1:0]      rr_idx;
    logic                  rr_vld;
    logic                  pass;

    assign pass = (state_q == ARB_PASS_S);
    assign req  = ast_valid_i & ast_startofpacket_i;

    rr_arbiter #(.N(N_PORTS)) u_rr (
        .req     (req),
        .last    (last_q),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    always_comb begin
        ast_data_o          = '0;
        ast_startofpacket_o = 1'b0;
        ast_endofpacket_o   = 1'b0;
        ast_valid_o         = 1'b0;
        ast_empty_o         = '0;
        ast_channel_o       = '0;
        if (pass) begin
            ast_data_o          = ast_data_i[grant_q];
            ast_startofpacket_o = ast_startofpacket_i[grant_q];
            ast_endofpacket_o   = ast_endofpacket_i[grant_q];
            ast_valid_o         = ast_valid_i[grant_q];
            ast_empty_o         = ast_empty_i[grant_q];
            ast_channel_o       = ast_channel_i[grant_q];
        end
    end

    // Granted port follows downstream ready; everyone else only sees drain ready.
    always_comb begin
        drain       = '0;
        ast_ready_o = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (pass && (grant_q == GNT_W'(k))) begin
                ast_ready_o[k] = ast_ready_i;
            end else begin
                drain[k]       = ast_valid_i[k] & ~ast_startofpacket_i[k];
                ast_ready_o[k] = drain[k];
            end
        end
        if (rst_i) begin
            drain       = '0;
            ast_ready_o = '0;
        end
    end

    always_comb begin
        drop_sum = {1'b0, drop_q};
        for (int k = 0; k < N_PORTS; k++) begin
            drop_sum = drop_sum + (DROP_CNT_W + 1)'(drain[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE_S: begin
                if (rr_vld) begin
                    grant_d = rr_idx;
                    state_d = ARB_PASS_S;
                end
            end
            ARB_PASS_S: begin
                if (ast_valid_o && ast_ready_i && ast_endofpacket_o) begin
                    last_d  = grant_q;
                    state_d = ARB_IDLE_S;
                end
            end
            default: state_d = ARB_IDLE_S;
        endcase
    end

    // last_q starts at N_PORTS-1 so port 0 wins the first arbitration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE_S;
            grant_q <= '0;
            last_q  <= GNT_W'(N_PORTS - 1);
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            drop_q  <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign grant_o    = grant_q;
    assign busy_o     = pass;
    assign drop_cnt_o = drop_q;

endmodule
